lsp_cb_rom_stream: RTL and testbench

Parametrised, clocked successor to the single-codebook LSP ROMs. It holds `NUM_CB` scalar LSP codebooks in signed Q15.16 fixed point (sign, 15 integer, 16 fraction bits). On request it streams one selected codebook entry by entry over a ready/valid interface into the `cbselect` distance search. An optional random-access read port serves dequantisation.

---
 rtl/lsp_cb_pkg.sv | 71 +++++++
 rtl/lsp_cb_table.sv | 18 +
 rtl/lsp_cb_rom_stream.sv | 134 +++++++++++++
 tb/tb_lsp_cb_rom_stream.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsp_cb_pkg.sv
// Shared constants, types and codebook contents for the LSP codebook ROM stream.
// Entries are signed Q15.16; CB_TABLE and CB_LEN are built once at elaboration.
package lsp_cb_pkg;

  localparam int N      = 32;
  localparam int DEPTH  = 16;
  localparam int NUM_CB = 10;
  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = $clog2(NUM_CB);

  typedef logic signed [N-1:0] entry_t;
  typedef logic [NUM_CB-1:0][DEPTH-1:0][N-1:0] cb_table_t;
  typedef logic [NUM_CB-1:0][AW:0] cb_len_t;

  typedef enum logic {IDLE, STREAM} state_t;

  // Each codebook is an arithmetic run: entry i = base + i*step (+ frac LSBs)
  typedef struct packed {
    int len;
    int base;
    int step;
    int frac;
  } cb_coef_t;

  function automatic cb_coef_t cb_coef(int unsigned k);
    cb_coef_t c;
    case (k)
      0:       c = '{len: 10, base:  100, step:   75, frac: 0};
      1:       c = '{len:  1, base: 3000, step:    0, frac: 0};
      2:       c = '{len: 16, base:  500, step:   50, frac: 0};
      3:       c = '{len: 12, base:  200, step:  120, frac: 0};
      4:       c = '{len: 16, base: -800, step:  100, frac: 0};
      5:       c = '{len:  8, base: 1000, step:  250, frac: 0};
      6:       c = '{len: 16, base:  150, step:  200, frac: 32768};
      7:       c = '{len:  5, base: 2500, step:  300, frac: 0};
      8:       c = '{len: 16, base:   50, step:   25, frac: 0};
      9:       c = '{len:  3, base: 3500, step: -400, frac: 0};
      default: c = '{len:  1, base:    0, step:    0, frac: 0};
    endcase
    return c;
  endfunction

  function automatic cb_table_t build_table();
    cb_table_t t;
    cb_coef_t  c;
    t = '0;
    for (int unsigned k = 0; k < NUM_CB; k++) begin
      c = cb_coef(k);
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (int'(i) < c.len)
          t[k][i] = N'((c.base + int'(i) * c.step) * 65536 + c.frac);
      end
    end
    return t;
  endfunction

  function automatic cb_len_t build_len();
    cb_len_t  l;
    cb_coef_t c;
    l = '0;
    for (int unsigned k = 0; k < NUM_CB; k++) begin
      c    = cb_coef(k);
      l[k] = (AW+1)'(c.len);
    end
    return l;
  endfunction

  localparam cb_table_t CB_TABLE = build_table();
  localparam cb_len_t   CB_LEN   = build_len();

endpackage

// File: rtl/lsp_cb_table.sv
// Combinational (codebook, address) -> Q15.16 entry lookup; zero when out of range.
module lsp_cb_table
  import lsp_cb_pkg::*;
(
  input  logic [CW-1:0] cb,
  input  logic [AW-1:0] addr,
  output entry_t        data,
  output logic          in_range
);

  always_comb begin
    in_range = (int'(cb) < NUM_CB) && (int'(addr) < DEPTH);
    data     = '0;
    if (in_range)
      data = CB_TABLE[cb][addr];
  end

endmodule

// File: rtl/lsp_cb_rom_stream.sv
// Streams one LSP codebook over ready/valid. Optional random-access read port
// is compiled in when LSP_CB_RA_EN is defined.
module lsp_cb_rom_stream
  import lsp_cb_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [CW-1:0] cb_sel,
  input  logic          abort,
  output logic          busy,
  output logic          out_valid,
  input  logic          out_ready,
  output entry_t        out_data,
  output logic [AW-1:0] out_idx,
  output logic          out_last,
  output logic          done,
  output logic          err
`ifdef LSP_CB_RA_EN
  ,
  input  logic          ra_en,
  input  logic [CW-1:0] ra_cb,
  input  logic [AW-1:0] ra_addr,
  output entry_t        ra_data,
  output logic          ra_err
`endif
);

  state_t        state;
  logic [CW-1:0] cb_q;

  logic [CW-1:0] lk_cb;
  logic [AW-1:0] lk_addr;
  logic [AW:0]   lk_len;
  logic          lk_last;
  logic          lk_ok;
  entry_t        lk_data;

  // One lookup serves both the first entry (from cb_sel) and every following one
  always_comb begin
    lk_cb   = (state == IDLE) ? cb_sel : cb_q;
    lk_addr = (state == IDLE) ? '0 : out_idx + AW'(1);
    lk_len  = '0;
    if (int'(lk_cb) < NUM_CB)
      lk_len = CB_LEN[lk_cb];
    lk_last = ({1'b0, lk_addr} == lk_len - (AW+1)'(1));
  end

  lsp_cb_table u_stream_tab (
    .cb       (lk_cb),
    .addr     (lk_addr),
    .data     (lk_data),
    .in_range (lk_ok)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cb_q      <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (lk_ok) begin
              cb_q      <= cb_sel;
              out_data  <= lk_data;
              out_idx   <= '0;
              out_valid <= 1'b1;
              out_last  <= lk_last;
              busy      <= 1'b1;
              state     <= STREAM;
            end else begin
              err <= 1'b1;
            end
          end
        end
        STREAM: begin
          if (abort) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else if (out_valid && out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= IDLE;
            end else begin
              out_data <= lk_data;
              out_idx  <= out_idx + AW'(1);
              out_last <= lk_last;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LSP_CB_RA_EN
  entry_t ra_lk_data;
  logic   ra_lk_ok;

  lsp_cb_table u_ra_tab (
    .cb       (ra_cb),
    .addr     (ra_addr),
    .data     (ra_lk_data),
    .in_range (ra_lk_ok)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra_data <= '0;
      ra_err  <= 1'b0;
    end else begin
      ra_err <= ra_en && !ra_lk_ok;
      if (ra_en)
        ra_data <= ra_lk_data;
    end
  end
`endif

endmodule

// File: tb/tb_lsp_cb_rom_stream.sv
// Directed bench for lsp_cb_rom_stream: a per-cycle vector table plus sequences
// for stalls, abort, mid-stream start, async reset and (LSP_CB_RA_EN) random access.
module tb_lsp_cb_rom_stream;
  import lsp_cb_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] cb_sel = '0;
  logic          abort = 1'b0;
  logic          out_ready = 1'b0;
  logic          busy, out_valid, out_last, done, err;
  logic [N-1:0]  out_data;
  logic [AW-1:0] out_idx;
`ifdef LSP_CB_RA_EN
  logic          ra_en = 1'b0;
  logic [CW-1:0] ra_cb = '0;
  logic [AW-1:0] ra_addr = '0;
  logic [N-1:0]  ra_data;
  logic          ra_err;
`endif

  lsp_cb_rom_stream dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cb_sel    (cb_sel),
    .abort     (abort),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .done      (done),
    .err       (err)
`ifdef LSP_CB_RA_EN
    ,
    .ra_en     (ra_en),
    .ra_cb     (ra_cb),
    .ra_addr   (ra_addr),
    .ra_data   (ra_data),
    .ra_err    (ra_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          st;
    logic [CW-1:0] cb;
    logic          ab;
    logic          rdy;
    logic          busy;
    logic          vld;
    logic [31:0]   data;
    logic [AW-1:0] idx;
    logic          last;
    logic          dn;
    logic          er;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [31:0] cb2(int i);
    return 32'h01F4_0000 + 32'(i) * 32'h0032_0000;
  endfunction

  function automatic vec_t mk(logic st, int cb, logic ab, logic rdy, logic bsy, logic vld,
                              logic [31:0] dat, int idx, logic lst, logic dn, logic er);
    vec_t v;
    v.st = st; v.cb = CW'(cb); v.ab = ab; v.rdy = rdy;
    v.busy = bsy; v.vld = vld; v.data = dat; v.idx = AW'(idx);
    v.last = lst; v.dn = dn; v.er = er;
    return v;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[$];
    vec_t        v;
    logic [31:0] pd;
    logic [AW-1:0] pi;
    logic        pstall;
    int          cnt;
    logic        seen;

    // Full cb2 stream, done in cycle 17, invalid select, length-1 codebook with a stall,
    // start during the done pulse, abort in IDLE ignored, abort beating a handshake.
    vecs.push_back(mk(1, 2, 0, 1, 1, 1, cb2(0), 0, 0, 0, 0));
    for (int i = 1; i < 16; i++)
      vecs.push_back(mk(0, 0, 0, 1, 1, 1, cb2(i), i, (i == 15), 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 32'h0, 0, 0, 1, 0));
    vecs.push_back(mk(1, NUM_CB, 0, 1, 0, 0, 32'h0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 1, 32'h0BB8_0000, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 32'h0BB8_0000, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 32'h0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 9, 0, 1, 1, 1, 32'h0DAC_0000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 32'h0C1C_0000, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 32'h0A8C_0000, 2, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 32'h0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 4, 1, 0, 1, 1, 32'hFCE0_0000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 32'h0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 32'h0, 0, 0, 0, 0));

    #1;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_valid", out_valid, 1'b0);
    chk1("rst_last", out_last, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_err", err, 1'b0);
    chkw("rst_data", out_data, 32'h0);
    chkw("rst_idx", 32'(out_idx), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      start = v.st; cb_sel = v.cb; abort = v.ab; out_ready = v.rdy;
      step();
      chk1($sformatf("vec%0d_busy", i), busy, v.busy);
      chk1($sformatf("vec%0d_valid", i), out_valid, v.vld);
      chk1($sformatf("vec%0d_last", i), out_last, v.last);
      chk1($sformatf("vec%0d_done", i), done, v.dn);
      chk1($sformatf("vec%0d_err", i), err, v.er);
      if (v.vld) begin
        chkw($sformatf("vec%0d_data", i), out_data, v.data);
        chkw($sformatf("vec%0d_idx", i), 32'(out_idx), 32'(v.idx));
      end
    end
    start = 1'b0; abort = 1'b0; out_ready = 1'b0; cb_sel = '0;

    // Pseudo-random backpressure: every beat exactly once, stable while stalled
    start = 1'b1; cb_sel = 2;
    step();
    start = 1'b0;
    pstall = 1'b0; cnt = 0; seen = 1'b0; pd = '0; pi = '0;
    for (int c = 0; c < 200 && !seen; c++) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (pstall && out_valid) begin
          chkw("stall_data", out_data, pd);
          chkw("stall_idx", 32'(out_idx), 32'(pi));
        end
        out_ready = ($urandom_range(0, 2) != 0);
        if (out_valid && out_ready) begin
          chkw("rnd_data", out_data, cb2(cnt));
          chkw("rnd_idx", 32'(out_idx), 32'(cnt));
          chk1("rnd_last", out_last, (cnt == 15));
          cnt++;
        end
        pstall = out_valid && !out_ready;
        pd = out_data;
        pi = out_idx;
        step();
      end
    end
    chk1("rnd_done_seen", seen, 1'b1);
    chkw("rnd_beats", 32'(cnt), 32'd16);
    out_ready = 1'b0;
    step();

    // Abort on beat 5 with out_ready high, then restart the following cycle
    start = 1'b1; cb_sel = 2; out_ready = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 20 && out_idx != 5; c++)
      step();
    chkw("abort_at_idx5", 32'(out_idx), 32'd5);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk1("abort_valid", out_valid, 1'b0);
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_last", out_last, 1'b0);
    chk1("abort_no_done0", done, 1'b0);
    start = 1'b1; cb_sel = 2;
    step();
    start = 1'b0;
    chk1("abort_no_done1", done, 1'b0);
    chk1("restart_valid", out_valid, 1'b1);
    chkw("restart_idx", 32'(out_idx), 32'd0);
    chkw("restart_data", out_data, cb2(0));
    abort = 1'b1;
    step();
    abort = 1'b0;
    step();

    // start with another cb_sel mid-stream must be ignored
    start = 1'b1; cb_sel = 2; out_ready = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k < 4; k++)
      step();
    start = 1'b1; cb_sel = 9;
    step();
    start = 1'b0;
    chk1("midstart_err", err, 1'b0);
    chkw("midstart_idx", 32'(out_idx), 32'd4);
    chkw("midstart_data", out_data, cb2(4));
    for (int k = 5; k < 16; k++) begin
      step();
      chkw($sformatf("midstart_data%0d", k), out_data, cb2(k));
    end
    chk1("midstart_last", out_last, 1'b1);
    step();
    chk1("midstart_done", done, 1'b1);
    chk1("midstart_busy", busy, 1'b0);

`ifdef LSP_CB_RA_EN
    // Random access alongside a running stream
    start = 1'b1; cb_sel = 2; out_ready = 1'b1;
    ra_en = 1'b1; ra_cb = 2; ra_addr = 7;
    step();
    start = 1'b0; ra_en = 1'b0;
    chkw("ra_data", ra_data, 32'h0352_0000);
    chk1("ra_err_ok", ra_err, 1'b0);
    chkw("ra_stream_data0", out_data, cb2(0));
    step();
    chkw("ra_hold", ra_data, 32'h0352_0000);
    chkw("ra_stream_data1", out_data, cb2(1));
    ra_en = 1'b1; ra_cb = CW'(NUM_CB); ra_addr = 0;
    step();
    ra_en = 1'b0;
    chkw("ra_bad_data", ra_data, 32'h0);
    chk1("ra_bad_err", ra_err, 1'b1);
    chkw("ra_stream_data2", out_data, cb2(2));
    step();
    chk1("ra_err_pulse", ra_err, 1'b0);
    abort = 1'b1;
    step();
    abort = 1'b0;
`endif

    // Asynchronous reset in mid-cycle while streaming
    start = 1'b1; cb_sel = 2; out_ready = 1'b0;
    step();
    start = 1'b0;
    chk1("prereset_valid", out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk1("arst_valid", out_valid, 1'b0);
    chk1("arst_busy", busy, 1'b0);
    chkw("arst_data", out_data, 32'h0);
    chkw("arst_idx", 32'(out_idx), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
